// File: rtl/meta_split.sv
// Splits a per-packet metadata word from an AXI-Stream payload. Packets whose first
// beat carries no valid metadata are discarded and counted.
//
// state | meaning
// FIRST | next accepted beat is the first beat of a packet
// PASS  | forwarding the body of a packet whose metadata was queued
// DROP  | discarding the body of a packet that had no metadata
module meta_split #(
  parameter int DATA_WIDTH = 64,
  parameter int META_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [META_WIDTH-1:0]   s_meta_in,
  input  logic                    s_meta_valid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [META_WIDTH-1:0]   m_meta_out,
  output logic                    m_meta_valid,
  input  logic                    m_meta_ready,
  output logic [15:0]             drop_count,
  output logic [15:0]             pkt_count
);

  typedef enum logic [1:0] {
    FIRST = 2'd0,
    PASS  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t state;
  logic   run;

  logic [META_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;

  logic slice_free;
  logic accept;
  logic first_meta;
  logic first_drop;
  logic push;
  logic pop;
  logic load;

  // Space freed by a same-cycle pop is deliberately not counted, keeping ready off the pop path.
  always_comb begin
    slice_free    = !m_axis_tvalid || m_axis_tready;
    s_axis_tready = 1'b0;
    if (run) begin
      case (state)
        FIRST:   s_axis_tready = slice_free && (fifo_cnt < 2'd2);
        PASS:    s_axis_tready = slice_free;
        DROP:    s_axis_tready = 1'b1;
        default: s_axis_tready = 1'b0;
      endcase
    end
  end

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign first_meta = accept && (state == FIRST) && s_meta_valid;
  assign first_drop = accept && (state == FIRST) && !s_meta_valid;
  assign push       = first_meta;
  assign load       = first_meta || (accept && (state == PASS));
  assign pop        = m_meta_valid && m_meta_ready;

  assign m_meta_valid = (fifo_cnt != 2'd0);
  assign m_meta_out   = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= FIRST;
      run        <= 1'b0;
      drop_count <= 16'd0;
      pkt_count  <= 16'd0;
    end else begin
      run <= 1'b1;
      if (first_meta) pkt_count <= pkt_count + 16'd1;
      if (first_drop && (drop_count != 16'hFFFF)) drop_count <= drop_count + 16'd1;
      if (accept) begin
        case (state)
          FIRST: begin
            if (!s_axis_tlast) state <= s_meta_valid ? PASS : DROP;
          end
          PASS, DROP: begin
            if (s_axis_tlast) state <= FIRST;
          end
          default: state <= FIRST;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= s_meta_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      m_axis_tdata <= s_axis_tdata;
      m_axis_tkeep <= s_axis_tkeep;
    end
  end

endmodule

// File: tb/tb_meta_split.sv
// Directed bench for meta_split: a per-cycle vector table for forwarding and dropping,
// then hand-written sequences for FIFO backpressure, egress stalls, reset and saturation.
module tb_meta_split;

  localparam int DW = 64;
  localparam int MW = 128;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [7:0]    s_axis_tkeep = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [MW-1:0] s_meta_in = '0;
  logic          s_meta_valid = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic [MW-1:0] m_meta_out;
  logic          m_meta_valid;
  logic          m_meta_ready = 1'b1;
  logic [15:0]   drop_count;
  logic [15:0]   pkt_count;

  int n_pass = 0;
  int n_total = 0;

  meta_split #(.DATA_WIDTH(DW), .META_WIDTH(MW)) dut (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .s_meta_in(s_meta_in), .s_meta_valid(s_meta_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .m_meta_out(m_meta_out), .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready),
    .drop_count(drop_count), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          tv, tl, smv;
    logic [DW-1:0] d;
    logic [MW-1:0] meta;
    logic          mr, qr;
    logic          e_rdy, e_mv;
    logic [DW-1:0] e_md;
    logic          e_ml, e_qv;
    logic [MW-1:0] e_q;
  } vec_t;

  vec_t tbl [11];

  localparam logic [MW-1:0] M1 = {8'hA5, 112'h0, 8'h01};
  localparam logic [MW-1:0] M2 = 128'h1234_5678;
  localparam logic [MW-1:0] Q1 = 128'h1111;
  localparam logic [MW-1:0] Q2 = 128'h2222;
  localparam logic [MW-1:0] Q3 = 128'h3333;
  localparam logic [MW-1:0] Q4 = 128'h4444;
  localparam logic [MW-1:0] Q5 = 128'h5555;
  localparam logic [MW-1:0] Q6 = 128'h6666;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic tv, input logic tl, input logic smv, input logic [DW-1:0] d,
                       input logic [MW-1:0] meta, input logic mr, input logic qr);
    s_axis_tvalid = tv;
    s_axis_tlast  = tl;
    s_meta_valid  = smv;
    s_axis_tdata  = d;
    s_axis_tkeep  = d[7:0];
    s_meta_in     = meta;
    m_axis_tready = mr;
    m_meta_ready  = qr;
  endtask

  function automatic vec_t mk(logic tv, logic tl, logic smv, logic [DW-1:0] d, logic [MW-1:0] meta,
                              logic mr, logic qr, logic e_rdy, logic e_mv, logic [DW-1:0] e_md,
                              logic e_ml, logic e_qv, logic [MW-1:0] e_q);
    vec_t v;
    v.tv = tv; v.tl = tl; v.smv = smv; v.d = d; v.meta = meta; v.mr = mr; v.qr = qr;
    v.e_rdy = e_rdy; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml; v.e_qv = e_qv; v.e_q = e_q;
    return v;
  endfunction

  initial begin
    int sent;
    int got;
    logic stall;
    logic acc;
    logic [DW-1:0] pd;
    logic [DW-1:0] dv;

    // 3-beat packet, then a 4-beat drop, then a single-beat packet under a one-cycle stall
    tbl[0]  = mk(1, 0, 1, 100, M1, 1, 1,  1, 1, 100, 0, 1, M1);
    tbl[1]  = mk(1, 0, 0, 101, 0,  1, 1,  1, 1, 101, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 102, 0,  1, 1,  1, 1, 102, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0,   0,  1, 1,  1, 0, 0,   0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 200, 0,  1, 1,  1, 0, 0,   0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 201, 0,  1, 1,  1, 0, 0,   0, 0, 0);
    tbl[6]  = mk(1, 0, 0, 202, 0,  1, 1,  1, 0, 0,   0, 0, 0);
    tbl[7]  = mk(1, 1, 0, 203, 0,  1, 1,  1, 0, 0,   0, 0, 0);
    tbl[8]  = mk(1, 1, 1, 300, M2, 1, 1,  1, 1, 300, 1, 1, M2);
    tbl[9]  = mk(0, 0, 0, 0,   0,  0, 0,  0, 1, 300, 1, 1, M2);
    tbl[10] = mk(0, 0, 0, 0,   0,  1, 1,  1, 0, 0,   0, 0, 0);

    // reset state
    #2;
    chk("rst_mvalid", m_axis_tvalid, 0);
    chk("rst_qvalid", m_meta_valid, 0);
    chk("rst_ready", s_axis_tready, 0);
    chk("rst_tlast", m_axis_tlast, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_pkt", pkt_count, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    #1 chk("ready_after_release", s_axis_tready, 0);
    tick();
    chk("ready_first_edge", s_axis_tready, 1);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].tv, tbl[i].tl, tbl[i].smv, tbl[i].d, tbl[i].meta, tbl[i].mr, tbl[i].qr);
      #1;
      chk($sformatf("v%0d_ready", i), s_axis_tready, tbl[i].e_rdy);
      tick();
      chk($sformatf("v%0d_mvalid", i), m_axis_tvalid, tbl[i].e_mv);
      if (tbl[i].e_mv) begin
        chk($sformatf("v%0d_mdata", i), m_axis_tdata, tbl[i].e_md);
        dv = tbl[i].e_md;
        chk($sformatf("v%0d_mkeep", i), m_axis_tkeep, dv[7:0]);
        chk($sformatf("v%0d_mlast", i), m_axis_tlast, tbl[i].e_ml);
      end
      chk($sformatf("v%0d_qvalid", i), m_meta_valid, tbl[i].e_qv);
      if (tbl[i].e_qv) chk($sformatf("v%0d_qdata", i), m_meta_out, tbl[i].e_q);
    end
    chk("tbl_pkt_count", pkt_count, 2);
    chk("tbl_drop_count", drop_count, 1);

    // two queued metas fill the FIFO; the third first beat waits for a pop
    drive(1, 1, 1, 400, Q1, 1, 0);
    #1 chk("fifo_rdy0", s_axis_tready, 1);
    tick();
    chk("fifo_head_q1", m_meta_out, Q1);
    drive(1, 1, 1, 401, Q2, 1, 0);
    #1 chk("fifo_rdy1", s_axis_tready, 1);
    tick();
    drive(1, 1, 1, 402, Q3, 1, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("fifo_full_stall", s_axis_tready, 0);
      chk("fifo_head_hold", m_meta_out, Q1);
      tick();
    end
    m_meta_ready = 1'b1;
    #1 chk("pop_not_space", s_axis_tready, 0);
    tick();
    m_meta_ready = 1'b0;
    #1;
    chk("fifo_rdy_after_pop", s_axis_tready, 1);
    chk("fifo_head_q2", m_meta_out, Q2);
    tick();
    s_axis_tvalid = 1'b0;
    chk("third_beat_data", m_axis_tdata, 402);
    chk("fifo_head_q2_held", m_meta_out, Q2);
    m_meta_ready = 1'b1;
    tick();
    chk("fifo_head_q3_valid", m_meta_valid, 1);
    chk("fifo_head_q3", m_meta_out, Q3);
    tick();
    chk("fifo_empty", m_meta_valid, 0);
    chk("fifo_pkt_count", pkt_count, 5);

    // 5-beat packet with egress ready toggling 1010...
    sent = 0;
    got = 0;
    stall = 1'b0;
    pd = '0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      drive(sent < 5, sent == 4, sent == 0, 64'(700 + sent), Q4, (c % 2) == 0, 1);
      #1;
      if (stall) chk("stall_hold", m_axis_tdata, pd);
      if (m_axis_tvalid && m_axis_tready) begin
        chk($sformatf("toggle_beat%0d", got), m_axis_tdata, 64'(700 + got));
        chk($sformatf("toggle_last%0d", got), m_axis_tlast, got == 4);
        got++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      acc = s_axis_tvalid && s_axis_tready;
      tick();
      if (acc) sent++;
    end
    chk("toggle_count", got, 5);
    drive(0, 0, 0, 0, 0, 1, 1);
    tick();
    chk("toggle_drained", m_axis_tvalid, 0);
    chk("toggle_pkt_count", pkt_count, 6);

    // reset pulsed after two beats of a 5-beat packet
    drive(1, 0, 1, 800, Q5, 1, 0);
    #1 chk("mid_rdy0", s_axis_tready, 1);
    tick();
    drive(1, 0, 0, 801, 0, 1, 0);
    #1 chk("mid_rdy1", s_axis_tready, 1);
    tick();
    s_axis_tvalid = 1'b0;
    rstn = 1'b0;
    #2;
    chk("mid_rst_mvalid", m_axis_tvalid, 0);
    chk("mid_rst_qvalid", m_meta_valid, 0);
    chk("mid_rst_ready", s_axis_tready, 0);
    chk("mid_rst_pkt", pkt_count, 0);
    chk("mid_rst_drop", drop_count, 0);
    tick();
    rstn = 1'b1;
    #1 chk("mid_rel_ready", s_axis_tready, 0);
    tick();
    chk("mid_first_edge_ready", s_axis_tready, 1);
    drive(1, 1, 1, 900, Q6, 1, 0);
    tick();
    s_axis_tvalid = 1'b0;
    chk("post_rst_mvalid", m_axis_tvalid, 1);
    chk("post_rst_data", m_axis_tdata, 900);
    chk("post_rst_last", m_axis_tlast, 1);
    chk("post_rst_qvalid", m_meta_valid, 1);
    chk("post_rst_meta", m_meta_out, Q6);
    chk("post_rst_pkt", pkt_count, 1);
    m_meta_ready = 1'b1;
    tick();
    chk("post_rst_qempty", m_meta_valid, 0);

    // drop counter saturation: one single-beat drop per cycle
    drive(1, 1, 0, 1000, 0, 1, 1);
    repeat (65534) tick();
    chk("drop_fffe", drop_count, 16'hFFFE);
    repeat (2) tick();
    chk("drop_ffff", drop_count, 16'hFFFF);
    repeat (3) tick();
    chk("drop_sat_hold", drop_count, 16'hFFFF);
    chk("drop_no_egress", m_axis_tvalid, 0);
    chk("drop_pkt_unchanged", pkt_count, 1);
    s_axis_tvalid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
